cskipa_exerciser: RTL and testbench

Self-checking stimulus/response engine that drives the operand inputs of a WIDTH-bit carry-skip adder and checks the adder's sum and carry-out.
It generates operand pairs, exhaustively or from an LFSR, and holds each pair for a settle window.
At the end of the window it compares the adder's response with the golden value operand1 + operand2.
It sits beside each generated adder in the batch characterisation flow and reports pass/fail, error count and the first failing vector.

---
 rtl/cskipa_exerciser.sv | 179 +++++++++++++++++
 tb/tb_cskipa_exerciser.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cskipa_exerciser.sv
// Stimulus/response engine for a WIDTH-bit carry-skip adder: walks operand pairs
// (exhaustive or LFSR), holds each for a settle window, then checks {cout,sum}.
`timescale 1ns/1ps
module cskipa_exerciser #(
    parameter int          WIDTH  = 4,
    parameter int          SETTLE = 2,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [15:0]      num_vec,
    output logic [WIDTH-1:0] o_add_term1,
    output logic [WIDTH-1:0] o_add_term2,
    input  logic [WIDTH-1:0] i_sum,
    input  logic             i_cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b
);

    localparam int LW = 2 * WIDTH;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    // Maximal-length Fibonacci tap masks; bit n-1 set for polynomial term x^n.
    function automatic logic [LW-1:0] lfsr_taps();
        logic [15:0] m;
        case (LW)
            2:       m = 16'h0003;
            3:       m = 16'h0006;
            4:       m = 16'h000C;
            5:       m = 16'h0014;
            6:       m = 16'h0030;
            7:       m = 16'h0060;
            8:       m = 16'h00B8;
            9:       m = 16'h0110;
            10:      m = 16'h0240;
            11:      m = 16'h0500;
            12:      m = 16'h0829;
            13:      m = 16'h100D;
            14:      m = 16'h2015;
            15:      m = 16'h6000;
            default: m = 16'hD008;
        endcase
        return m[LW-1:0];
    endfunction

    localparam logic [LW-1:0] TAPS     = lfsr_taps();
    localparam logic [LW-1:0] SEED_LOW = SEED[LW-1:0];
    localparam logic [LW-1:0] SEED_EFF = (SEED_LOW == '0) ? LW'(1) : SEED_LOW;
    localparam logic [15:0]   EXH_LAST = 16'((32'd1 << LW) - 32'd1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_CHECK,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_mode;
    logic [15:0]       r_last;
    logic [15:0]       r_vec;
    logic [SW-1:0]     r_settle;
    logic [LW-1:0]     r_lfsr;
    logic [WIDTH-1:0]  r_term1;
    logic [WIDTH-1:0]  r_term2;
    logic [15:0]       r_err_count;
    logic [WIDTH-1:0]  r_fail_a;
    logic [WIDTH-1:0]  r_fail_b;
    logic              r_first_fail;

    logic              w_start_ok;
    logic [LW-1:0]     w_src;
    logic [WIDTH:0]    w_golden;
    logic              w_mismatch;
    logic              w_last;
    logic [LW-1:0]     w_lfsr_next;
    logic [15:0]       w_last_sel;

    assign w_start_ok  = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_src       = r_mode ? r_lfsr : r_vec[LW-1:0];
    assign w_golden    = {1'b0, r_term1} + {1'b0, r_term2};
    assign w_mismatch  = ({i_cout, i_sum} != w_golden);
    assign w_last      = (r_vec == r_last);
    assign w_lfsr_next = {r_lfsr[LW-2:0], ^(r_lfsr & TAPS)};
    // A zero LFSR count still runs one vector.
    assign w_last_sel  = mode ? ((num_vec == 16'd0) ? 16'd0 : 16'(num_vec - 16'd1))
                              : EXH_LAST;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE,
            S_DONE:  if (start) w_state_next = S_LOAD;
            S_LOAD:  w_state_next = S_HOLD;
            S_HOLD:  if (r_settle == '0) w_state_next = S_CHECK;
            S_CHECK: w_state_next = w_last ? S_DONE : S_LOAD;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode       <= 1'b0;
            r_last       <= '0;
            r_vec        <= '0;
            r_settle     <= '0;
            r_lfsr       <= SEED_EFF;
            r_term1      <= '0;
            r_term2      <= '0;
            r_err_count  <= '0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
            r_first_fail <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE,
                S_DONE: begin
                    if (w_start_ok) begin
                        r_mode       <= mode;
                        r_last       <= w_last_sel;
                        r_vec        <= '0;
                        r_err_count  <= '0;
                        r_fail_a     <= '0;
                        r_fail_b     <= '0;
                        r_first_fail <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_term1  <= w_src[WIDTH-1:0];
                    r_term2  <= w_src[LW-1:WIDTH];
                    r_settle <= SW'(SETTLE - 1);
                end
                S_HOLD: begin
                    if (r_settle != '0) r_settle <= r_settle - SW'(1);
                end
                S_CHECK: begin
                    if (w_mismatch) begin
                        if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
                        if (!r_first_fail) begin
                            r_fail_a     <= r_term1;
                            r_fail_b     <= r_term2;
                            r_first_fail <= 1'b1;
                        end
                    end
                    r_vec <= r_vec + 16'd1;
                    // The LFSR only advances for LFSR-mode vectors and is never reseeded by start.
                    if (r_mode) r_lfsr <= w_lfsr_next;
                end
                default: ;
            endcase
        end
    end

    assign o_add_term1 = r_term1;
    assign o_add_term2 = r_term2;
    assign busy        = (r_state == S_LOAD) || (r_state == S_HOLD) || (r_state == S_CHECK);
    assign done        = (r_state == S_DONE);
    assign pass        = done && (r_err_count == 16'd0);
    assign err_count   = r_err_count;
    assign fail_a      = r_fail_a;
    assign fail_b      = r_fail_b;

endmodule

// File: tb/tb_cskipa_exerciser.sv
// Scoreboard bench for cskipa_exerciser: a behavioural adder with selectable
// faults sits on the adder ports; expected operand sequences are queued per run.
`timescale 1ns/1ps
module tb_cskipa_exerciser;

    localparam int WIDTH  = 4;
    localparam int SETTLE = 2;
    localparam int PERIOD = SETTLE + 2;

    typedef enum {F_IDEAL, F_COUT_SA0, F_SUM2_INV} fault_t;
    typedef struct packed {
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] a;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             mode;
    logic [15:0]      num_vec;
    logic [WIDTH-1:0] o_add_term1;
    logic [WIDTH-1:0] o_add_term2;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
    logic             done;
    logic             pass;
    logic [15:0]      err_count;
    logic [WIDTH-1:0] fail_a;
    logic [WIDTH-1:0] fail_b;

    fault_t           fault = F_IDEAL;
    logic [WIDTH:0]   ideal;
    logic [7:0]       m_lfsr = 8'hE1;
    vec_t             q_exp[$];
    int               n_vec = 0;
    int               n_err = 0;

    cskipa_exerciser #(.WIDTH(WIDTH), .SETTLE(SETTLE), .SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .num_vec(num_vec),
        .o_add_term1(o_add_term1), .o_add_term2(o_add_term2),
        .i_sum(sum), .i_cout(cout),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_a(fail_a), .fail_b(fail_b)
    );

    always #5 clk = ~clk;

    // Adder under check, with an optional planted defect.
    always_comb begin
        ideal = {1'b0, o_add_term1} + {1'b0, o_add_term2};
        sum   = ideal[WIDTH-1:0];
        cout  = ideal[WIDTH];
        if (fault == F_COUT_SA0) cout = 1'b0;
        if (fault == F_SUM2_INV) sum[2] = ~ideal[2];
    end

    // x^8+x^6+x^5+x^4+1, shifting toward the MSB.
    task automatic model_lfsr_step();
        logic fb;
        fb     = m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3];
        m_lfsr = {m_lfsr[6:0], fb};
    endtask

    function automatic bit exp_mismatch(input vec_t v);
        int s;
        s = int'(v.a) + int'(v.b);
        case (fault)
            F_COUT_SA0: return (s >= 16);
            F_SUM2_INV: return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

    task automatic check_all_zero(input string name);
        logic [47:0] obs;
        obs = {o_add_term1, o_add_term2, busy, done, pass, err_count, fail_a, fail_b, 5'd0};
        n_vec++;
        if (obs !== 48'd0) begin
            n_err++;
            $display("FAIL %s: outputs %h, required all zero", name, obs);
        end
    endtask

    // One run: queue the expected vectors, start, follow the DUT cycle by cycle.
    task automatic run_case(input string name, input logic m, input logic [15:0] nv,
                            input int glitch_t, input int force_t, input int abort_t,
                            input logic [15:0] abort_err);
        int               nvec;
        int               limit;
        int               t;
        int               exp_err;
        bit               seen;
        logic [WIDTH-1:0] exp_fa;
        logic [WIDTH-1:0] exp_fb;
        logic [15:0]      idx;
        vec_t             v;
        vec_t             got;

        nvec    = m ? ((nv == 16'd0) ? 1 : int'(nv)) : 256;
        limit   = nvec * PERIOD + 1;
        exp_err = 0;
        seen    = 1'b0;
        exp_fa  = '0;
        exp_fb  = '0;
        q_exp.delete();
        for (int k = 0; k < nvec; k++) begin
            if (m) begin
                v.a = m_lfsr[3:0];
                v.b = m_lfsr[7:4];
                model_lfsr_step();
            end else begin
                idx = 16'(k);
                v.a = idx[3:0];
                v.b = idx[7:4];
            end
            q_exp.push_back(v);
            if (exp_mismatch(v)) begin
                if (exp_err < 65535) exp_err++;
                if (!seen) begin
                    seen   = 1'b1;
                    exp_fa = v.a;
                    exp_fb = v.b;
                end
            end
        end

        @(negedge clk);
        mode    = m;
        num_vec = nv;
        start   = 1'b1;
        t       = 0;
        while (t < limit + 4) begin
            @(posedge clk);
            t++;
            @(negedge clk);
            start = 1'b0;
            if (t == glitch_t) begin
                start   = 1'b1;
                mode    = ~m;
                num_vec = 16'd7;
            end
            if (force_t > 0 && t == force_t) force dut.r_err_count = 16'hFFFD;
            if (force_t > 0 && t == force_t + 1) release dut.r_err_count;
            if (t == 1) begin
                n_vec++;
                if ({busy, done} !== 2'b10) begin
                    n_err++;
                    $display("FAIL %s busy_after_start: busy,done=%b required 10", name, {busy, done});
                end
            end
            if (t >= 2 && (t - 2) % PERIOD == 0 && q_exp.size() > 0) begin
                v     = q_exp.pop_front();
                got.a = o_add_term1;
                got.b = o_add_term2;
                n_vec++;
                if (got !== v) begin
                    n_err++;
                    $display("FAIL %s operands t=%0d: a=%h b=%h required a=%h b=%h",
                             name, t, got.a, got.b, v.a, v.b);
                end
            end
            if (t == abort_t) begin
                n_vec++;
                if (err_count !== abort_err) begin
                    n_err++;
                    $display("FAIL %s err_before_reset: %h required %h", name, err_count, abort_err);
                end
                rst = 1'b1;
                #1;
                check_all_zero({name, "_async_reset"});
                @(negedge clk);
                rst    = 1'b0;
                m_lfsr = 8'hE1;
                q_exp.delete();
                return;
            end
            if (done === 1'b1) break;
        end

        n_vec++;
        if (t != limit || done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s run_length: %0d cycles done=%b busy=%b, required %0d cycles done=1 busy=0",
                     name, t, done, busy, limit);
        end
        n_vec++;
        if (err_count !== 16'(exp_err)) begin
            n_err++;
            $display("FAIL %s err_count: %0d required %0d", name, err_count, exp_err);
        end
        n_vec++;
        if (pass !== (exp_err == 0)) begin
            n_err++;
            $display("FAIL %s pass: %b required %b", name, pass, (exp_err == 0));
        end
        n_vec++;
        if ({fail_a, fail_b} !== {exp_fa, exp_fb}) begin
            n_err++;
            $display("FAIL %s first_fail: a=%h b=%h required a=%h b=%h",
                     name, fail_a, fail_b, exp_fa, exp_fb);
        end
        n_vec++;
        if (q_exp.size() != 0) begin
            n_err++;
            $display("FAIL %s vectors_seen: %0d left unobserved, required 0", name, q_exp.size());
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        start   = 1'b0;
        mode    = 1'b0;
        num_vec = 16'd0;
        fault   = F_IDEAL;
        m_lfsr  = 8'hE1;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({busy, done} !== 2'b00) begin
            n_err++;
            $display("FAIL idle_hold: busy,done=%b required 00", {busy, done});
        end
    endtask

    task automatic test_exhaustive_ideal();
        fault = F_IDEAL;
        run_case("exh_ideal", 1'b0, 16'd0, 0, 0, 0, 16'd0);
    endtask

    task automatic test_reset_mid_run();
        // t=150 is the first HOLD cycle of vector 37; only vector 31 (15+1) has failed.
        fault = F_COUT_SA0;
        run_case("exh_abort", 1'b0, 16'd0, 0, 0, 150, 16'd1);
    endtask

    task automatic test_exhaustive_cout_sa0();
        fault = F_COUT_SA0;
        run_case("exh_cout_sa0", 1'b0, 16'd0, 0, 0, 0, 16'd0);
    endtask

    task automatic test_lfsr();
        fault = F_SUM2_INV;
        run_case("lfsr_run1", 1'b1, 16'd10, 0, 0, 0, 16'd0);
        run_case("lfsr_run2", 1'b1, 16'd10, 0, 0, 0, 16'd0);
    endtask

    task automatic test_busy_start_and_zero();
        fault = F_SUM2_INV;
        run_case("zero_vec_glitch", 1'b1, 16'd0, 2, 0, 0, 16'd0);
    endtask

    task automatic test_saturation();
        fault = F_SUM2_INV;
        run_case("saturate", 1'b1, 16'hFFFF, 0, 3, 30, 16'hFFFF);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_exhaustive_ideal();
        test_reset_mid_run();
        test_exhaustive_cout_sa0();
        test_lfsr();
        test_busy_start_and_zero();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
